code_word_sel_dbuf: RTL and testbench

CODE_WORD_SEL_DBUF -- requirements
Module: code_word_sel_dbuf

---
 rtl/code_word_sel_dbuf.sv | 135 +++++++++++++
 tb/tb_code_word_sel_dbuf.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_word_sel_dbuf.sv
// Double-buffered codeword table with per-beam phase / sorted-index selection.
// Writes fill the shadow bank sequentially; a swap commits it as the active bank.
module code_word_sel_dbuf #(
    parameter int unsigned ANTS  = 32,
    parameter int unsigned BEAM  = 16,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 64
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  logic                                i_wr_vld,
    input  logic [$clog2(DEPTH)-1:0]            i_wr_addr,
    input  logic [WIDTH*ANTS-1:0]               i_wr_even,
    input  logic [WIDTH*ANTS-1:0]               i_wr_odd,
    input  logic                                i_swap,
    input  logic [BEAM-1:0][$clog2(DEPTH)-1:0]  i_beam_idx,
    input  logic                                i_rbg_load,
    input  logic [7:0]                          i_symb_idx,
    input  logic                                i_symb_clr,
    input  logic                                i_symb_1st,
    output logic [BEAM-1:0][WIDTH*ANTS-1:0]     o_cw_even,
    output logic [BEAM-1:0][WIDTH*ANTS-1:0]     o_cw_odd,
    output logic                                o_tvalid,
    output logic                                o_wr_err,
    output logic                                o_swap_err,
    output logic                                o_active_bank
);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned PH  = DEPTH / BEAM;
    localparam int unsigned PHW = (PH > 1) ? $clog2(PH) : 1;
    localparam int unsigned CW  = WIDTH * ANTS;
    localparam int unsigned MW  = AW + 1;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2
    } load_state_t;

    load_state_t state;
    logic [MW-1:0]           wr_cnt;
    logic                    wr_ok;
    logic                    swap_ok;
    logic [PHW-1:0]          symb_phase;
    logic [PHW-1:0]          s1_phase;
    logic                    s1_first;
    logic                    unused_symb;
    logic [BEAM-1:0][CW-1:0] sel_even;
    logic [BEAM-1:0][CW-1:0] sel_odd;

    // Both banks in one array: index MSB is the bank.
    logic [CW-1:0] mem_even [2*DEPTH];
    logic [CW-1:0] mem_odd  [2*DEPTH];

    assign wr_ok       = i_wr_vld && (i_wr_addr == wr_cnt[AW-1:0]) && (state != ST_FULL);
    assign swap_ok     = i_swap && !i_wr_vld && (state == ST_FULL);
    assign symb_phase  = (PH > 1) ? i_symb_idx[PHW-1:0] : '0;
    assign unused_symb = &{1'b0, i_symb_idx};

    // Load FSM, write counter, bank pointer and error pulses.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= ST_EMPTY;
            wr_cnt        <= '0;
            o_active_bank <= 1'b0;
            o_tvalid      <= 1'b0;
            o_wr_err      <= 1'b0;
            o_swap_err    <= 1'b0;
        end else begin
            o_wr_err   <= i_wr_vld && !wr_ok;
            o_swap_err <= i_swap && !swap_ok;
            if (swap_ok) begin
                state         <= ST_EMPTY;
                wr_cnt        <= '0;
                o_active_bank <= ~o_active_bank;
                o_tvalid      <= 1'b1;
            end else if (wr_ok) begin
                wr_cnt <= wr_cnt + MW'(1);
                state  <= (wr_cnt == MW'(DEPTH - 1)) ? ST_FULL : ST_FILLING;
            end
        end
    end

    // Table storage; never reset, writes land in the shadow bank only.
    always_ff @(posedge i_clk) begin
        if (wr_ok && !i_reset) begin
            mem_even[{~o_active_bank, i_wr_addr}] <= i_wr_even;
            mem_odd[{~o_active_bank, i_wr_addr}]  <= i_wr_odd;
        end
    end

    // Sorted-index prefetch from the active bank, refreshed every cycle.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < BEAM; i++) begin
            sel_even[i] <= mem_even[{o_active_bank, i_beam_idx[i]}];
            sel_odd[i]  <= mem_odd[{o_active_bank, i_beam_idx[i]}];
        end
    end

    // Symbol stage S1: phase and first-symbol flag.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s1_phase <= '0;
            s1_first <= 1'b0;
        end else if (i_symb_clr) begin
            s1_phase <= '0;
            s1_first <= 1'b1;
        end else begin
            s1_phase <= symb_phase;
            s1_first <= i_symb_1st;
        end
    end

    // Per-beam output update: clear > first-symbol phase > sorted load > hold.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_cw_even <= '0;
            o_cw_odd  <= '0;
        end else begin
            for (int i = 0; i < BEAM; i++) begin
                if (i_symb_clr) begin
                    o_cw_even[i] <= mem_even[{o_active_bank, AW'(i)}];
                    o_cw_odd[i]  <= mem_odd[{o_active_bank, AW'(i)}];
                end else if (s1_first) begin
                    o_cw_even[i] <= mem_even[{o_active_bank, AW'(int'(s1_phase) * int'(BEAM) + i)}];
                    o_cw_odd[i]  <= mem_odd[{o_active_bank, AW'(int'(s1_phase) * int'(BEAM) + i)}];
                end else if (i_rbg_load) begin
                    o_cw_even[i] <= sel_even[i];
                    o_cw_odd[i]  <= sel_odd[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_code_word_sel_dbuf.sv
// Self-checking bench for code_word_sel_dbuf: fill/swap, error pulses, phase and sorted select, reset mid-fill.
module tb_code_word_sel_dbuf;
    localparam int unsigned ANTS  = 32;
    localparam int unsigned BEAM  = 16;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = WIDTH * ANTS;

    logic                         i_clk = 1'b0;
    logic                         i_reset;
    logic                         i_wr_vld;
    logic [AW-1:0]                i_wr_addr;
    logic [CW-1:0]                i_wr_even;
    logic [CW-1:0]                i_wr_odd;
    logic                         i_swap;
    logic [BEAM-1:0][AW-1:0]      i_beam_idx;
    logic                         i_rbg_load;
    logic [7:0]                   i_symb_idx;
    logic                         i_symb_clr;
    logic                         i_symb_1st;
    logic [BEAM-1:0][CW-1:0]      o_cw_even;
    logic [BEAM-1:0][CW-1:0]      o_cw_odd;
    logic                         o_tvalid;
    logic                         o_wr_err;
    logic                         o_swap_err;
    logic                         o_active_bank;

    code_word_sel_dbuf #(
        .ANTS (ANTS),
        .BEAM (BEAM),
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_wr_vld     (i_wr_vld),
        .i_wr_addr    (i_wr_addr),
        .i_wr_even    (i_wr_even),
        .i_wr_odd     (i_wr_odd),
        .i_swap       (i_swap),
        .i_beam_idx   (i_beam_idx),
        .i_rbg_load   (i_rbg_load),
        .i_symb_idx   (i_symb_idx),
        .i_symb_clr   (i_symb_clr),
        .i_symb_1st   (i_symb_1st),
        .o_cw_even    (o_cw_even),
        .o_cw_odd     (o_cw_odd),
        .o_tvalid     (o_tvalid),
        .o_wr_err     (o_wr_err),
        .o_swap_err   (o_swap_err),
        .o_active_bank(o_active_bank)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        string         tag;
        int            beam;
        logic [CW-1:0] ev;
        logic [CW-1:0] od;
    } exp_t;

    exp_t          sb[$];
    logic [CW-1:0] m_even [2][DEPTH];
    logic [CW-1:0] m_odd  [2][DEPTH];
    bit            m_bank;
    bit            err_acc;
    int            n_vec = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h exp %h (low 64 bits)", tag, got[63:0], exp[63:0]);
        end
    endtask

    function automatic logic [CW-1:0] cw_data(input int gen, input int addr, input bit odd);
        logic [CW-1:0] d;
        for (int k = 0; k < int'(ANTS); k++)
            d[k*WIDTH +: WIDTH] = {8'(gen), 8'(addr), 8'(k), 7'd0, odd};
        return d;
    endfunction

    function automatic int beam_sel(input int b);
        return (b * 11 + 17) % int'(DEPTH);
    endfunction

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wr(input int addr, input int gen, input bit ok);
        i_wr_vld  = 1'b1;
        i_wr_addr = AW'(addr);
        i_wr_even = cw_data(gen, addr, 1'b0);
        i_wr_odd  = cw_data(gen, addr, 1'b1);
        cyc();
        i_wr_vld = 1'b0;
        if (ok) begin
            m_even[~m_bank][addr] = cw_data(gen, addr, 1'b0);
            m_odd[~m_bank][addr]  = cw_data(gen, addr, 1'b1);
        end
        err_acc = err_acc | o_wr_err;
    endtask

    task automatic fill(input int lo, input int hi, input int gen);
        for (int a = lo; a <= hi; a++) wr(a, gen, 1'b1);
    endtask

    task automatic swap(input bit with_wr);
        i_swap = 1'b1;
        if (with_wr) begin
            i_wr_vld  = 1'b1;
            i_wr_addr = '0;
            i_wr_even = cw_data(9, 0, 1'b0);
            i_wr_odd  = cw_data(9, 0, 1'b1);
        end
        cyc();
        i_swap   = 1'b0;
        i_wr_vld = 1'b0;
    endtask

    task automatic push(input string tag, input int beam, input int addr);
        exp_t e;
        e.tag  = tag;
        e.beam = beam;
        e.ev   = m_even[m_bank][addr];
        e.od   = m_odd[m_bank][addr];
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("%s_b%0d_even", e.tag, e.beam), o_cw_even[e.beam], e.ev);
            chk($sformatf("%s_b%0d_odd", e.tag, e.beam), o_cw_odd[e.beam], e.od);
        end
    endtask

    task automatic symb_clr(input string tag);
        i_symb_clr = 1'b1;
        for (int b = 0; b < int'(BEAM); b++) push(tag, b, b);
        cyc();
        i_symb_clr = 1'b0;
        drain();
        cyc();
        cyc();
    endtask

    task automatic rbg_load(input string tag);
        i_rbg_load = 1'b1;
        for (int b = 0; b < int'(BEAM); b++) push(tag, b, beam_sel(b));
        cyc();
        i_rbg_load = 1'b0;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset    = 1'b1;
        i_wr_vld   = 1'b0;
        i_wr_addr  = '0;
        i_wr_even  = '0;
        i_wr_odd   = '0;
        i_swap     = 1'b0;
        i_beam_idx = '0;
        i_rbg_load = 1'b0;
        i_symb_idx = '0;
        i_symb_clr = 1'b0;
        i_symb_1st = 1'b0;
        m_bank     = 1'b0;
        err_acc    = 1'b0;
        cyc();
        cyc();
        i_reset = 1'b0;

        chk("rst_cw_even_b0", o_cw_even[0], '0);
        chk("rst_cw_odd_b15", o_cw_odd[15], '0);
        chk("rst_tvalid", CW'(o_tvalid), '0);
        chk("rst_bank", CW'(o_active_bank), '0);
        chk("rst_wr_err", CW'(o_wr_err), '0);
        chk("rst_swap_err", CW'(o_swap_err), '0);

        // Full fill of shadow bank 1, then commit.
        err_acc = 1'b0;
        fill(0, 63, 1);
        chk("fill1_no_wr_err", CW'(err_acc), '0);
        swap(1'b0);
        m_bank = 1'b1;
        chk("swap1_bank", CW'(o_active_bank), CW'(1));
        chk("swap1_tvalid", CW'(o_tvalid), CW'(1));
        chk("swap1_swap_err", CW'(o_swap_err), '0);
        chk("swap1_wr_err", CW'(o_wr_err), '0);

        // First-symbol phase select: phase 2 -> entry i+32, two cycles later.
        i_symb_idx = 8'd2;
        i_symb_1st = 1'b1;
        for (int b = 0; b < int'(BEAM); b++) push("phase2", b, b + 32);
        cyc();
        i_symb_1st = 1'b0;
        i_symb_idx = 8'd0;
        chk("phase2_latency_b5", o_cw_even[5], '0);
        cyc();
        drain();

        symb_clr("clr_bank1");

        // Sorted select: beam 3 -> index 50.
        for (int b = 0; b < int'(BEAM); b++) i_beam_idx[b] = AW'(beam_sel(b));
        cyc();
        chk("sel_latency_b3", o_cw_even[3], m_even[1][3]);
        rbg_load("sorted_bank1");

        // Out-of-order write, then early swap, into shadow bank 0.
        err_acc = 1'b0;
        fill(0, 4, 2);
        wr(7, 9, 1'b0);
        chk("ooo_wr_err", CW'(o_wr_err), CW'(1));
        wr(5, 2, 1'b1);
        chk("inorder_after_err", CW'(o_wr_err), '0);
        err_acc = 1'b0;
        fill(6, 39, 2);
        chk("fill2a_no_wr_err", CW'(err_acc), '0);
        swap(1'b0);
        chk("early_swap_err", CW'(o_swap_err), CW'(1));
        chk("early_swap_bank", CW'(o_active_bank), CW'(1));
        cyc();
        chk("swap_err_pulse_end", CW'(o_swap_err), '0);
        err_acc = 1'b0;
        fill(40, 63, 2);
        chk("fill2b_no_wr_err", CW'(err_acc), '0);

        // Swap colliding with a write while FULL.
        swap(1'b1);
        chk("collide_swap_err", CW'(o_swap_err), CW'(1));
        chk("collide_wr_err", CW'(o_wr_err), CW'(1));
        chk("collide_bank", CW'(o_active_bank), CW'(1));
        swap(1'b0);
        m_bank = 1'b0;
        chk("swap2_bank", CW'(o_active_bank), '0);
        chk("swap2_swap_err", CW'(o_swap_err), '0);
        chk("swap2_tvalid", CW'(o_tvalid), CW'(1));
        chk("hold_after_swap_b3", o_cw_even[3], m_even[1][50]);
        cyc();
        rbg_load("reload_bank0");
        symb_clr("clr_bank0");

        // Reset mid-fill at wr_cnt=30.
        fill(0, 29, 3);
        i_reset = 1'b1;
        cyc();
        i_reset = 1'b0;
        m_bank  = 1'b0;
        chk("midrst_tvalid", CW'(o_tvalid), '0);
        chk("midrst_bank", CW'(o_active_bank), '0);
        chk("midrst_cw_even_b3", o_cw_even[3], '0);
        chk("midrst_cw_odd_b3", o_cw_odd[3], '0);
        chk("midrst_cw_even_b5", o_cw_even[5], '0);
        swap(1'b0);
        chk("midrst_empty_swap_err", CW'(o_swap_err), CW'(1));
        wr(30, 5, 1'b0);
        chk("midrst_addr30_wr_err", CW'(o_wr_err), CW'(1));
        err_acc = 1'b0;
        fill(0, 63, 4);
        chk("refill_no_wr_err", CW'(err_acc), '0);
        swap(1'b0);
        m_bank = 1'b1;
        chk("swap3_bank", CW'(o_active_bank), CW'(1));
        chk("swap3_tvalid", CW'(o_tvalid), CW'(1));
        symb_clr("clr_refill");
        rbg_load("sorted_refill");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
